// File: rtl/median_sched_pkg.sv
// Shared constants, state encoding and helpers for the median_sched scheduler.
package median_sched_pkg;

  localparam int unsigned PIX_COUNT = 9;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned ST_W      = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  // Index of the final pixel of a 3x3 window.
  function automatic logic [IDX_W-1:0] last_idx();
    return IDX_W'(PIX_COUNT - 1);
  endfunction

endpackage

// File: rtl/median_sched_arb.sv
// One-hot winner selection from the request vector.
// MEDIAN_SCHED_RR_EN: search starts at i_ptr and wraps; otherwise lowest index wins.
module median_sched_arb #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
`ifdef MEDIAN_SCHED_RR_EN
  input  logic [$clog2(NREQ)-1:0] i_ptr,
`endif
  output logic [NREQ-1:0]         o_gnt_c
);

  logic w_found;

`ifdef MEDIAN_SCHED_RR_EN
  // Offset k from the pointer is tried in order; the first requesting slot wins.
  always_comb begin
    o_gnt_c = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!w_found && (j == ((32'(i_ptr) + k) % NREQ)) && i_req[j]) begin
          o_gnt_c[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    o_gnt_c = '0;
    w_found = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!w_found && i_req[j]) begin
        o_gnt_c[j] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/median_sched.sv
// Shares one MEDIAN 3x3 operator between NREQ requesters: grant, stream nine pixels, await result.
// Build option MEDIAN_SCHED_RR_EN selects round-robin arbitration (fixed priority otherwise).
module median_sched
  import median_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NREQ-1:0]             REQ,
  input  logic [NREQ-1:0][WIDTH-1:0]  PIX,
  output logic [NREQ-1:0]             GNT,
  output logic [IDX_W-1:0]            IDX,
  output logic [NREQ-1:0]             DONE,
  output logic [WIDTH-1:0]            RES,
  output logic                        BUSY,
  output logic [WIDTH-1:0]            MED_DI,
  output logic                        MED_DSI,
  input  logic [WIDTH-1:0]            MED_DO,
  input  logic                        MED_DSO
);

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_gnt,   w_gnt_nxt;
  logic [IDX_W-1:0] r_idx,   w_idx_nxt;
  logic [NREQ-1:0]  r_done,  w_done_nxt;
  logic [WIDTH-1:0] r_res,   w_res_nxt;
  logic             r_busy,  w_busy_nxt;
  logic [WIDTH-1:0] r_di,    w_di_nxt;
  logic             r_dsi,   w_dsi_nxt;
  logic [NREQ-1:0]  w_win;
  logic [WIDTH-1:0] w_pix;

`ifdef MEDIAN_SCHED_RR_EN
  localparam int unsigned PTR_W = $clog2(NREQ);
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_gidx, w_ptr_inc;

  // Pointer moves to the slot after the requester being completed.
  always_comb begin
    w_gidx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) w_gidx = PTR_W'(i);
    end
  end
  assign w_ptr_inc = (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + PTR_W'(1);
`endif

  median_sched_arb #(.NREQ(NREQ)) u_arb (
    .i_req   (REQ),
`ifdef MEDIAN_SCHED_RR_EN
    .i_ptr   (r_ptr),
`endif
    .o_gnt_c (w_win)
  );

  // Granted lane's pixel, selected by the one-hot grant.
  always_comb begin
    w_pix = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_pix = w_pix | (PIX[i] & {WIDTH{r_gnt[i]}});
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_done_nxt  = '0;
    w_res_nxt   = r_res;
    w_busy_nxt  = r_busy;
    w_di_nxt    = r_di;
    w_dsi_nxt   = 1'b0;
`ifdef MEDIAN_SCHED_RR_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (|REQ) begin
          w_gnt_nxt   = w_win;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_di_nxt  = w_pix;
        w_dsi_nxt = 1'b1;
        if (r_idx == last_idx()) begin
          w_state_nxt = WAIT;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      WAIT: begin
        if (MED_DSO) begin
          w_res_nxt   = MED_DO;
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
`ifdef MEDIAN_SCHED_RR_EN
          w_ptr_nxt   = w_ptr_inc;
`endif
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_done  <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_di    <= '0;
      r_dsi   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      r_res   <= w_res_nxt;
      r_busy  <= w_busy_nxt;
      r_di    <= w_di_nxt;
      r_dsi   <= w_dsi_nxt;
    end
  end

`ifdef MEDIAN_SCHED_RR_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_ptr <= '0;
    else     r_ptr <= w_ptr_nxt;
  end
`endif

  assign GNT     = r_gnt;
  assign IDX     = r_idx;
  assign DONE    = r_done;
  assign RES     = r_res;
  assign BUSY    = r_busy;
  assign MED_DI  = r_di;
  assign MED_DSI = r_dsi;

endmodule

// File: tb/tb_median_sched.sv
// Self-checking bench for median_sched with a behavioural MEDIAN operator model.
module tb_median_sched;

  localparam int NREQ = 4;

  logic                 CLK, RST;
  logic [3:0]           REQ;
  logic [3:0][7:0]      PIX;
  logic [3:0]           GNT, DONE;
  logic [3:0]           IDX;
  logic [7:0]           RES, MED_DI, med_do;
  logic                 BUSY, MED_DSI, med_dso;

  logic [0:8][7:0]      lane_pix [NREQ];
  int                   vectors = 0;
  int                   miscompares = 0;
  int                   mptr = 0;

  median_sched #(.NREQ(4), .WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .PIX(PIX), .GNT(GNT), .IDX(IDX),
    .DONE(DONE), .RES(RES), .BUSY(BUSY), .MED_DI(MED_DI), .MED_DSI(MED_DSI),
    .MED_DO(med_do), .MED_DSO(med_dso)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Requester lanes answer the current index combinationally.
  always_comb begin
    for (int g = 0; g < NREQ; g++) PIX[g] = (IDX <= 4'd8) ? lane_pix[g][IDX] : 8'h00;
  end

  function automatic logic [7:0] med9(input logic [0:8][7:0] p);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = p[i];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  // Behavioural MEDIAN: collects nine DSI samples, raises DSO after a random latency.
  logic [0:8][7:0] mbuf;
  int mcnt, mwait;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcnt <= 0; mwait <= 0; med_dso <= 1'b0; med_do <= 8'h00;
    end else if (MED_DSI) begin
      mbuf[mcnt] <= MED_DI;
      mcnt       <= mcnt + 1;
      med_dso    <= 1'b0;
      if (mcnt == 8) mwait <= int'($urandom_range(1, 5));
    end else if (mwait == 1) begin
      med_dso <= 1'b1;
      med_do  <= med9(mbuf);
      mwait   <= 0;
      mcnt    <= 0;
    end else if (mwait > 1) begin
      mwait <= mwait - 1;
    end
  end

  // Shortest DSI-low gap between consecutive loads.
  int gap = 0, min_gap = 1000;
  bit prev_dsi = 1'b0, seen_load = 1'b0;
  always @(posedge CLK) begin
    if (MED_DSI && !prev_dsi && seen_load && gap < min_gap) min_gap <= gap;
    if (MED_DSI) begin gap <= 0; seen_load <= 1'b1; end
    else gap <= gap + 1;
    prev_dsi <= MED_DSI;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  // One transaction from the current negedge through the cycle after DONE.
  task automatic txn(input string nm, input logic [3:0] req, input logic [3:0] exp_g,
                     input logic [7:0] exp_r, input bit keep);
    int dsi_n = 0;
    bit got = 1'b0, gnt_bad = 1'b0;
    logic [3:0] g_seen = 4'h0;
    REQ = req;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge CLK);
      if (MED_DSI) dsi_n++;
      if (GNT != 4'h0 && g_seen == 4'h0) g_seen = GNT;
      if (GNT != 4'h0 && GNT != g_seen) gnt_bad = 1'b1;
      if (DONE != 4'h0) got = 1'b1;
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " gnt"}, 32'(g_seen), 32'(exp_g));
    chk({nm, " gnt_stable"}, 32'(gnt_bad), 32'd0);
    chk({nm, " done"}, 32'(DONE), 32'(exp_g));
    chk({nm, " res"}, 32'(RES), 32'(exp_r));
    chk({nm, " dsi_cycles"}, 32'(dsi_n), 32'd9);
    chk({nm, " gnt_clear"}, 32'(GNT), 32'd0);
    for (int i = 0; i < NREQ; i++) if (exp_g[i]) mptr = (i + 1) % NREQ;
    if (!keep) REQ = 4'h0;
    @(negedge CLK);
    chk({nm, " done_pulse"}, 32'(DONE), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mptr = 0;
  endtask

  typedef struct packed {
    logic [3:0]      req;
    logic [0:8][7:0] pix;
    logic [3:0]      gnt;
    logic [7:0]      res;
  } vec_t;

  vec_t tbl [4];
  int   exp_all [5];
  int   exp_two [4];

  initial begin
    tbl[0] = '{4'b0010, {8'd9, 8'd200, 8'd3, 8'd77, 8'd77, 8'd150, 8'd0, 8'd255, 8'd12}, 4'b0010, 8'd77};
    tbl[1] = '{4'b0001, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 4'b0001, 8'd5};
    tbl[2] = '{4'b1000, {8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 4'b1000, 8'd0};
    tbl[3] = '{4'b0100, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd80, 8'd90}, 4'b0100, 8'd50};
`ifdef MEDIAN_SCHED_RR_EN
    exp_all = '{0, 1, 2, 3, 0};
    exp_two = '{0, 1, 0, 1};
`else
    exp_all = '{0, 0, 0, 0, 0};
    exp_two = '{0, 0, 0, 1};
`endif
    RST = 1'b1;
    REQ = 4'h0;
    for (int g = 0; g < NREQ; g++) lane_pix[g] = '0;
    repeat (2) @(negedge CLK);
    chk("rst gnt", 32'(GNT), 32'd0);
    chk("rst idx", 32'(IDX), 32'd0);
    chk("rst done", 32'(DONE), 32'd0);
    chk("rst res", 32'(RES), 32'd0);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst di", 32'(MED_DI), 32'd0);
    chk("rst dsi", 32'(MED_DSI), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    for (int v = 0; v < 4; v++) begin
      for (int g = 0; g < NREQ; g++) lane_pix[g] = tbl[v].pix;
      txn($sformatf("tbl%0d", v), tbl[v].req, tbl[v].gnt, tbl[v].res, 1'b0);
    end

    // Everybody requesting; lane g answers 10*g+1 everywhere.
    do_reset();
    for (int g = 0; g < NREQ; g++)
      for (int k = 0; k < 9; k++) lane_pix[g][k] = 8'(10 * g + 1);
    for (int t = 0; t < 5; t++)
      txn($sformatf("all%0d", t), 4'b1111, 4'(1 << exp_all[t]), 8'(10 * exp_all[t] + 1), t != 4);

    // Two requesters held for three transactions, then requester 0 drops.
    do_reset();
    for (int t = 0; t < 3; t++)
      txn($sformatf("two%0d", t), 4'b0011, 4'(1 << exp_two[t]), 8'(10 * exp_two[t] + 1), t != 2);
    txn("two3", 4'b0010, 4'(1 << exp_two[3]), 8'(10 * exp_two[3] + 1), 1'b0);

    // REQ[2] withdrawn mid-load: the transaction still completes.
    begin
      bit hit = 1'b0, got = 1'b0;
      lane_pix[2] = {8'd5, 8'd90, 8'd33, 8'd61, 8'd2, 8'd200, 8'd47, 8'd47, 8'd120};
      REQ = 4'b0100;
      for (int c = 0; c < 50 && !hit; c++) begin
        @(negedge CLK);
        if (GNT == 4'b0100 && IDX == 4'd4) hit = 1'b1;
      end
      chk("drop idx4_seen", 32'(hit), 32'd1);
      REQ = 4'h0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge CLK);
        if (DONE != 4'h0) got = 1'b1;
      end
      chk("drop done", 32'(DONE), 32'b0100);
      chk("drop res", 32'(RES), 32'd47);
      repeat (3) @(negedge CLK);
      chk("drop no_regrant", 32'({BUSY, GNT}), 32'd0);
    end

    // Asynchronous reset in the middle of a load.
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 9; k++) lane_pix[0][k] = 8'(k * 20 + 3);
      REQ = 4'b0001;
      for (int c = 0; c < 50 && !hit; c++) begin
        @(negedge CLK);
        if (IDX == 4'd5) hit = 1'b1;
      end
      chk("rstmid idx5_seen", 32'(hit), 32'd1);
      #2 RST = 1'b1;
      #1;
      chk("rstmid gnt", 32'(GNT), 32'd0);
      chk("rstmid done", 32'(DONE), 32'd0);
      chk("rstmid dsi", 32'(MED_DSI), 32'd0);
      chk("rstmid busy", 32'(BUSY), 32'd0);
      chk("rstmid idx", 32'(IDX), 32'd0);
      chk("rstmid res", 32'(RES), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      mptr = 0;
      txn("rstmid clean", 4'b0001, 4'b0001, 8'd83, 1'b0);
    end

    // Random regression against the reference arbiter and a software sort.
    do_reset();
    for (int t = 0; t < 1000; t++) begin
      logic [3:0] r;
      int w;
      r = 4'($urandom_range(1, 15));
      for (int g = 0; g < NREQ; g++)
        for (int k = 0; k < 9; k++) lane_pix[g][k] = 8'($urandom);
`ifdef MEDIAN_SCHED_RR_EN
      w = winner(r, mptr);
`else
      w = winner(r, 0);
`endif
      txn($sformatf("rnd%0d", t), r, 4'(1 << w), med9(lane_pix[w]), 1'b0);
    end

    chk("dsi min_gap_ok", 32'(min_gap >= 2 && min_gap < 1000), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
